uart_cmd_framer: RTL

- Sits between the DUT's UART receiver/transmitter and the command-config stage of the QuadCopter.
- Assembles the 3-byte host packet (cmd, data_hi, data_lo) sent by the remote into a parallel cmd/data word with a cmd_rdy/clr_cmd_rdy handshake.
- Serializes the 1-byte response (ack, typically 8'hA5) back through the UART transmitter.
- Guards against stalled packets with an inter-byte timeout.

---
 rtl/uart_cmd_framer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: builds {cmd, data_hi, data_lo} host packets from the UART
// receiver into a cmd/data word with a cmd_rdy handshake, and serializes
// one-byte responses to the UART transmitter. A stalled packet is dropped
// after TIMEOUT_CYC idle cycles and answered with NAK_BYTE.
// Optional build macro UART_CHKSUM_EN adds a 4th checksum byte per packet,
// checksum = ~(cmd + data_hi + data_lo) mod 256; a bad checksum is a frame error.
module uart_cmd_framer #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0]  NAK_BYTE    = 8'hEE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic        cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        resp_sent,
    output logic        frame_err
);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_HI,
        RX_LO,
`ifdef UART_CHKSUM_EN
        RX_CHK,
`endif
        RX_COMMIT
    } rx_state_t;

    typedef enum logic { TX_IDLE, TX_BUSY } tx_state_t;

    rx_state_t   rx_state_q, rx_state_d;
    tx_state_t   tx_state_q, tx_state_d;
    logic [7:0]  cmd_sh_q, cmd_sh_d, hi_sh_q, hi_sh_d, lo_sh_q, lo_sh_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        clr_rx_q;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic        ferr_q;
    logic        pend_q, pend_d;
    logic [7:0]  pend_byte_q, pend_byte_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        trmt_q, trmt_d;
    logic        resp_sent_q, resp_sent_d;
    logic        accept, nak_req, timed_out;

    // A byte is taken only when the previous clr pulse is not in flight,
    // so a still-high rx_rdy during the knock-down cycle is not re-read.
    assign accept    = rx_rdy & ~clr_rx_q;
    assign timed_out = (to_cnt_q == TO_LAST);

`ifdef UART_CHKSUM_EN
    logic [7:0] chk_sum;
    assign chk_sum = ~(cmd_sh_q + hi_sh_q + lo_sh_q);
`endif

    // RX packet assembly, inter-byte timeout and cmd_rdy handshake.
    always_comb begin
        rx_state_d = rx_state_q;
        cmd_sh_d   = cmd_sh_q;
        hi_sh_d    = hi_sh_q;
        lo_sh_d    = lo_sh_q;
        to_cnt_d   = 32'd0;
        nak_req    = 1'b0;
        cmd_d      = cmd_q;
        data_d     = data_q;
        cmd_rdy_d  = cmd_rdy_q;
        if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (accept) begin
                    cmd_sh_d   = rx_data;
                    cmd_rdy_d  = 1'b0;
                    rx_state_d = RX_HI;
                end
            end
            RX_HI: begin
                if (accept) begin
                    hi_sh_d    = rx_data;
                    rx_state_d = RX_LO;
                end else if (timed_out) begin
                    nak_req    = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                end
            end
            RX_LO: begin
                if (accept) begin
                    lo_sh_d = rx_data;
`ifdef UART_CHKSUM_EN
                    rx_state_d = RX_CHK;
`else
                    rx_state_d = RX_COMMIT;
`endif
                end else if (timed_out) begin
                    nak_req    = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                end
            end
`ifdef UART_CHKSUM_EN
            RX_CHK: begin
                if (accept) begin
                    if (rx_data == chk_sum) begin
                        rx_state_d = RX_COMMIT;
                    end else begin
                        nak_req    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end
                end else if (timed_out) begin
                    nak_req    = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                end
            end
`endif
            RX_COMMIT: begin
                // Commit overrides a same-cycle clr_cmd_rdy.
                cmd_d      = cmd_sh_q;
                data_d     = {hi_sh_q, lo_sh_q};
                cmd_rdy_d  = 1'b1;
                rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // TX sequencing with a one-deep, last-wins pending slot. Order of
    // precedence within a cycle: older pending, then send_resp, then NAK.
    always_comb begin
        tx_state_d  = tx_state_q;
        pend_d      = pend_q;
        pend_byte_d = pend_byte_q;
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        resp_sent_d = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (pend_q) begin
                    tx_data_d   = pend_byte_q;
                    trmt_d      = 1'b1;
                    tx_state_d  = TX_BUSY;
                    pend_d      = send_resp | nak_req;
                    pend_byte_d = nak_req ? NAK_BYTE : resp;
                end else if (send_resp) begin
                    tx_data_d   = resp;
                    trmt_d      = 1'b1;
                    tx_state_d  = TX_BUSY;
                    pend_d      = nak_req;
                    pend_byte_d = NAK_BYTE;
                end else if (nak_req) begin
                    tx_data_d  = NAK_BYTE;
                    trmt_d     = 1'b1;
                    tx_state_d = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (send_resp || nak_req) begin
                    pend_d      = 1'b1;
                    pend_byte_d = nak_req ? NAK_BYTE : resp;
                end
                if (tx_done) begin
                    resp_sent_d = 1'b1;
                    tx_state_d  = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // State and output registers; reset aborts any packet or transmit silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q  <= RX_IDLE;
            tx_state_q  <= TX_IDLE;
            cmd_sh_q    <= 8'd0;
            hi_sh_q     <= 8'd0;
            lo_sh_q     <= 8'd0;
            to_cnt_q    <= 32'd0;
            clr_rx_q    <= 1'b0;
            cmd_rdy_q   <= 1'b0;
            cmd_q       <= 8'd0;
            data_q      <= 16'd0;
            ferr_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_byte_q <= 8'd0;
            tx_data_q   <= 8'd0;
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            tx_state_q  <= tx_state_d;
            cmd_sh_q    <= cmd_sh_d;
            hi_sh_q     <= hi_sh_d;
            lo_sh_q     <= lo_sh_d;
            to_cnt_q    <= to_cnt_d;
            clr_rx_q    <= accept;
            cmd_rdy_q   <= cmd_rdy_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            ferr_q      <= nak_req;
            pend_q      <= pend_d;
            pend_byte_q <= pend_byte_d;
            tx_data_q   <= tx_data_d;
            trmt_q      <= trmt_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    assign clr_rx_rdy = clr_rx_q;
    assign cmd_rdy    = cmd_rdy_q;
    assign cmd        = cmd_q;
    assign data       = data_q;
    assign trmt       = trmt_q;
    assign tx_data    = tx_data_q;
    assign resp_sent  = resp_sent_q;
    assign frame_err  = ferr_q;
endmodule
